// File: rtl/srff_bank_if.sv
// Control, data and status bundle for srff_bank.
// master drives the inputs and observes state; slave is the storage bank.
interface srff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [1:0]       pol;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             conflict_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, mode, pol, s, r, conflict_clr,
    input  q, qn, chg, conflict, conflict_cnt
  );

  modport slave (
    input  en, mode, pol, s, r, conflict_clr,
    output q, qn, chg, conflict, conflict_cnt
  );
endinterface

// File: rtl/srff_bank.sv
// Bank of WIDTH storage bits with run-time SR/JK/D/T mode, defined SR conflict policy,
// sticky conflict flags and a saturating conflict counter. Latency 1 cycle; no backpressure (en=0 holds).
module srff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic        clk,
  input  logic        rst_n,
  srff_bank_if.slave  bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [1:0] POL_HOLD = 2'b00;
  localparam logic [1:0] POL_SET  = 2'b01;
  localparam logic [1:0] POL_RST  = 2'b10;
  localparam logic [1:0] POL_TOG  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] r_conflict;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_conf;
  logic             w_any_conf;

  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.mode)
        MODE_SR, MODE_JK: begin
          case ({bus.s[i], bus.r[i]})
            2'b10:   w_q_nxt[i] = 1'b1;
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b11: begin
              if (bus.mode == MODE_JK) begin
                w_q_nxt[i] = ~r_q[i];
              end else begin
                case (bus.pol)
                  POL_HOLD: w_q_nxt[i] = r_q[i];
                  POL_SET:  w_q_nxt[i] = 1'b1;
                  POL_RST:  w_q_nxt[i] = 1'b0;
                  POL_TOG:  w_q_nxt[i] = ~r_q[i];
                  default:  w_q_nxt[i] = r_q[i];
                endcase
              end
            end
            default: w_q_nxt[i] = r_q[i];
          endcase
        end
        MODE_D:  w_q_nxt[i] = bus.s[i];
        MODE_T:  w_q_nxt[i] = bus.s[i] ^ r_q[i];
        default: w_q_nxt[i] = r_q[i];
      endcase
    end
  end

  // Only an enabled SR-mode update can conflict; JK/D/T have a defined 11 meaning.
  assign w_conf     = (bus.en && (bus.mode == MODE_SR)) ? (bus.s & bus.r) : {WIDTH{1'b0}};
  assign w_any_conf = |w_conf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= RESET_VAL;
      r_chg      <= {WIDTH{1'b0}};
      r_conflict <= {WIDTH{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      if (bus.en) begin
        r_q   <= w_q_nxt;
        r_chg <= w_q_nxt ^ r_q;
      end else begin
        r_chg <= {WIDTH{1'b0}};
      end

      // A conflict in the clearing cycle survives the clear.
      r_conflict <= (bus.conflict_clr ? {WIDTH{1'b0}} : r_conflict) | w_conf;

      if (bus.conflict_clr) begin
        r_cnt <= w_any_conf ? CNT_ONE : {CNT_W{1'b0}};
      end else if (w_any_conf && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign bus.q            = r_q;
  assign bus.qn           = ~r_q;
  assign bus.chg          = r_chg;
  assign bus.conflict     = r_conflict;
  assign bus.conflict_cnt = r_cnt;

endmodule

// File: doc/srff_bank.md
# srff_bank

Parametrised bank of WIDTH independent set/reset storage bits with a run-time selectable next-state mode (SR, JK, D, T). In SR mode, S=R=1 resolves by a programmable conflict policy rather than producing an unknown value. The block records each conflict in sticky per-bit flags and in a saturating event counter. It is the general-purpose flag/status register primitive for control and status logic that needs a defined state under every input combination.

## Interface
- WIDTH, 8, number of storage bits (1..64)
- CNT_W, 8, width of the conflict event counter (1..32)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset

- clk, in, 1, rising-edge clock
- rst_n, in, 1, reset, asynchronous, active-low
- en, in, 1, update enable; 0 = hold all state
- mode, in, 2, 00 SR, 01 JK, 10 D, 11 T
- pol, in, 2, SR-mode S=R=1 policy: 00 hold, 01 set-dominant, 10 reset-dominant, 11 toggle
- s, in, WIDTH, set / J / D / T input per bit
- r, in, WIDTH, reset / K input per bit (ignored in D and T modes)
- conflict_clr, in, 1, synchronous clear of conflict and conflict_cnt
- q, out, WIDTH, stored value (registered)
- qn, out, WIDTH, ~q (combinational from q)
- chg, out, WIDTH, registered; bit i high for one cycle after an edge where q[i] changed
- conflict, out, WIDTH, sticky per-bit flag: S=R=1 seen in SR mode
- conflict_cnt, out, CNT_W, saturating count of cycles with at least one SR conflict

## Operation
- Reset (rst_n=0, asynchronous, any time): q=RESET_VAL, qn=~RESET_VAL, chg=0, conflict=0, conflict_cnt=0. State remains held while rst_n=0. First update occurs on the first rising edge after deassertion.
- en=0: q, conflict and conflict_cnt hold; chg=0 on the next edge. conflict_clr is still honoured.
- en=1, per bit i, next q[i]:
  - SR: 10→1, 01→0, 00→hold, 11→per pol (hold / 1 / 0 / ~q[i]).
  - JK: 10→1, 01→0, 00→hold, 11→~q[i]. pol is ignored.
  - D: s[i]. r is ignored.
  - T: s[i] ? ~q[i] : q[i]. r is ignored.
- Conflict definition: en=1, mode=SR and s[i]&r[i]=1 at the edge. JK, D and T modes never produce conflicts.
- conflict[i]: set on a conflict; cleared by conflict_clr. A new conflict in the same cycle as conflict_clr wins, so the bit ends at 1.
- conflict_cnt: +1 on any edge where the conflict vector is nonzero, regardless of how many bits conflict. Saturates at 2^CNT_W-1 and never wraps.
- conflict_clr on conflict_cnt: with no conflict that cycle the count goes to 0; with a conflict that cycle it goes to 1.
- chg[i] = (next q[i] != q[i]) registered on the same edge as q.
- mode and pol are sampled every edge with no pipelining. A mode change applies on the edge at which it is sampled and leaves q otherwise untouched.
- No X is ever produced from known inputs.

## Timing
- Latency: inputs sampled at edge N → q, chg, conflict and conflict_cnt valid after edge N (1 cycle).
- qn is combinational from q, so it changes in the same cycle as q.
- All outputs are registered except qn. There are no combinational paths from inputs to outputs.
- The asynchronous reset acts immediately on assertion. Deassertion must be synchronised externally to clk.

## Test plan
- Reset: RESET_VAL=8'hA5, assert rst_n=0 mid-cycle → q=8'hA5 and qn=8'h5A immediately, conflict=0, cnt=0, chg=0. Release, drive en=0 → state unchanged.
- SR truth table, pol sweep: q=8'h0F, s=8'hFF, r=8'hFF, mode=00:
  - pol=00 → q=8'h0F
  - pol=01 → 8'hFF
  - pol=10 → 8'h00
  - pol=11 → toggles (8'h0F→8'hF0)
  - Each edge: conflict=8'hFF, cnt increments by 1.
- Modes:
  - JK s=r=8'hFF from 8'h3C → 8'hC3, no conflict.
  - D s=8'h96 → q=8'h96.
  - T s=8'h01 twice from 8'h00 → 8'h01 then 8'h00; chg=8'h01 both cycles.
- Counter saturation: CNT_W=2, 5 consecutive conflict cycles → cnt 1,2,3,3,3.
- conflict_clr with simultaneous conflict on bit 0 only → conflict=8'h01, cnt=1. Next cycle clr alone → conflict=0, cnt=0.
- en=0 with s=8'hFF, r=0 → q holds, chg=0, no conflict counted.
